// File: rtl/decoder_pkg.sv
// Shared definitions for the 4-to-16 hold decoder: FSM states, the idle
// output pattern and the active-low one-hot helper.
package decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [15:0] Y_NONE = 16'hFFFF;

    function automatic logic [15:0] onehot_n(input logic [3:0] code);
        return ~(16'h0001 << code);
    endfunction

endpackage

// File: rtl/decoder4_16_hold_sync2.sv
// Generic-width two-flop synchroniser with an asynchronous active-low reset
// to a parameterised value.
module sync2 #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/decoder4_16_hold.sv
// Receive side of the 16-to-4 priority encoder: synchronise and debounce the
// code, decode to active-low one-hot, hold each line, and count new codes.
module decoder4_16_hold
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic [3:0]       z,
    input  logic             gs_n,
    input  logic             eo_n,
    output logic [15:0]      y,
    output logic             valid,
    output logic             event_o,   // "event" is a reserved word
    output logic [CNT_W-1:0] evt_count,
    output logic             err
);

    localparam int unsigned    HCW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_RELOAD = HCW'(HOLD_CYCLES - 1);

    logic [5:0]       s2;
    logic [5:0]       prv_q;
    logic             stable;
    logic             qual;
    logic             bad;
    logic [3:0]       new_code;

    state_t           state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [15:0]      y_q, y_d;
    logic             valid_q, valid_d;
    logic             event_q, event_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic             err_q, err_d;

    sync2 #(
        .W       (6),
        .RST_VAL (6'h3F)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({z, gs_n, eo_n}),
        .q_o   (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prv_q <= 6'h3F;
        else        prv_q <= s2;
    end

    // Debounce: a sample counts only once it matched the previous one.
    assign stable   = (s2 == prv_q);
    assign qual     = stable & ~s2[1] &  s2[0];
    assign bad      = stable & ~s2[1] & ~s2[0];
    assign new_code = ~s2[5:2];

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        y_d     = y_q;
        valid_d = valid_q;
        event_d = 1'b0;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q | bad;

        case (state_q)
            IDLE: begin
                if (qual && !en_n) begin
                    state_d = HOLD;
                    code_d  = new_code;
                    y_d     = onehot_n(new_code);
                    valid_d = 1'b1;
                    event_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    hold_d  = HOLD_RELOAD;
                end
            end
            HOLD: begin
                if (en_n) begin
                    state_d = IDLE;
                    y_d     = Y_NONE;
                    valid_d = 1'b0;
                    hold_d  = '0;
                end else if (qual) begin
                    if (new_code != code_q) begin
                        code_d  = new_code;
                        y_d     = onehot_n(new_code);
                        event_d = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                    hold_d = HOLD_RELOAD;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HCW'(1);
                end else begin
                    state_d = IDLE;
                    y_d     = Y_NONE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = Y_NONE;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            y_q     <= Y_NONE;
            valid_q <= 1'b0;
            event_q <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign y         = y_q;
    assign valid     = valid_q;
    assign event_o   = event_q;
    assign evt_count = cnt_q;
    assign err       = err_q;

endmodule
